// File: rtl/result_port_tx_pkg.sv
// Shared definitions for the host result port: bus field layout and FSM states.
package result_port_tx_pkg;

    localparam int STROBE_BIT = 23;
    localparam int LAST_BIT   = 22;
    localparam int SEQ_LSB    = 16;
    localparam int SEQ_W      = 6;
    localparam int DATA_W     = 16;
    localparam int BUS_W      = 24;
    localparam int ENTRY_W    = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_t;

    function automatic logic [BUS_W-1:0] pack_bus(
        input logic              strobe,
        input logic              last,
        input logic [SEQ_W-1:0]  seq,
        input logic [DATA_W-1:0] data
    );
        return {strobe, last, seq, data};
    endfunction

endpackage

// File: rtl/result_port_tx_fifo.sv
// Small first-word-fall-through FIFO buffering {last, data} result entries.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/result_port_tx.sv
// Result transmit port: buffers convolution results and hands them to an
// asynchronous host through a four-phase strobe/ack handshake.
module result_port_tx
    import result_port_tx_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              host_ack,
    output logic [BUS_W-1:0]  out_bus,
    output logic              busy
);

    localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);

    tx_state_t          state;
    logic [CNT_W-1:0]   setup_cnt;
    logic [SEQ_W-1:0]   seq;
    logic               ack_meta;
    logic               ack_s;
    logic               rdy_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // rdy_en keeps in_ready low until the first edge after reset releases.
    assign in_ready = rdy_en && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_IDLE) && !fifo_empty && !ack_s;
    assign busy     = !fifo_empty || (state != ST_IDLE);

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_last, in_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            ack_meta <= host_ack;
            ack_s    <= ack_meta;
            rdy_en   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_bus   <= '0;
            seq       <= '0;
            setup_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        out_bus   <= pack_bus(1'b0, head[DATA_W], seq, head[DATA_W-1:0]);
                        setup_cnt <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        out_bus[STROBE_BIT] <= 1'b1;
                        state               <= ST_STROBE;
                    end else begin
                        setup_cnt <= setup_cnt + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (ack_s) begin
                        out_bus[STROBE_BIT] <= 1'b0;
                        seq   <= out_bus[LAST_BIT] ? '0 : seq + SEQ_W'(1);
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_port_tx.sv
// Randomized self-checking bench for result_port_tx with a word-queue reference model.
module tb_result_port_tx;

    localparam int DEPTH = 4;
    localparam int SETUP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        host_ack;
    logic [23:0] out_bus;
    logic        busy;

    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;
    bit   host_auto = 1'b0;
    int   host_dly = 0;

    assign host_ack = host_auto ? auto_ack : man_ack;

    result_port_tx #(
        .FIFO_DEPTH   (DEPTH),
        .SETUP_CYCLES (SETUP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .host_ack (host_ack),
        .out_bus  (out_bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // Reference model: words awaiting transmission, and the next sequence number.
    logic [16:0] model_q[$];
    logic [5:0]  exp_seq = '0;
    logic [16:0] mon_head;

    int          n_rise = 0;
    int          rise_cyc = 0;
    logic [23:0] rise_bus = '0;
    logic [23:0] prev_bus = '0;
    int          hold_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            prev_bus = '0;
            hold_cnt = 0;
        end else begin
            if (out_bus[23] && !prev_bus[23]) begin
                check("setup_hold", 32'((out_bus[22:0] == prev_bus[22:0]) && (hold_cnt >= SETUP)), 32'd1);
                if (model_q.size() == 0) begin
                    check("spurious_strobe", 32'(out_bus), 32'd0);
                end else begin
                    mon_head = model_q.pop_front();
                    check("word", 32'(out_bus), 32'({1'b1, mon_head[16], exp_seq, mon_head[15:0]}));
                    exp_seq = mon_head[16] ? 6'd0 : exp_seq + 6'd1;
                end
                n_rise++;
                rise_cyc = cyc;
                rise_bus = out_bus;
            end else if (!out_bus[23] && prev_bus[23]) begin
                check("strobe_fall_hold", 32'(out_bus[22:0]), 32'(rise_bus[22:0]));
            end
            hold_cnt = (out_bus[22:0] == prev_bus[22:0]) ? hold_cnt + 1 : 1;
            prev_bus = out_bus;
        end
    end

    // Host: raise ack after strobe rises, drop it after strobe falls.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                auto_ack = 1'b0;
            end else if (host_auto) begin
                if (out_bus[23] && !auto_ack) begin
                    repeat ((host_dly > 0) ? $urandom_range(0, host_dly) : 0) @(negedge clk);
                    auto_ack = 1'b1;
                end else if (!out_bus[23] && auto_ack) begin
                    repeat ((host_dly > 0) ? $urandom_range(0, host_dly) : 0) @(negedge clk);
                    auto_ack = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            model_q.push_back({l, d});
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (n_rise < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n_rise < target) check("rise_timeout", 32'(n_rise), 32'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || model_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_model", 32'(model_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_bus", 32'(out_bus), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_q.delete();
        exp_seq = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int base;
        #1 rst = 1'b1;
        do_reset();

        // Single word, ideal host: value and accept-to-strobe latency.
        host_auto = 1'b1;
        host_dly  = 0;
        base = n_rise;
        send(16'hABCD, 1'b0);
        wait_rises(base + 1);
        check("first_word", 32'(rise_bus), 32'h80ABCD);
        check("first_latency", 32'(rise_cyc - acc_cyc), 32'(SETUP + 1));
        wait_idle();

        // Back-pressure: host holds ack low, 4 queued plus 1 in flight.
        host_auto = 1'b0;
        man_ack   = 1'b0;
        for (int i = 0; i < 5; i++) send(16'($urandom), 1'b0);
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        host_dly  = 3;
        host_auto = 1'b1;
        wait_idle();

        // Sequence wrap, then clear after a last word.
        do_reset();
        host_dly = 0;
        for (int i = 0; i < 66; i++) begin
            base = n_rise;
            send(16'($urandom), i == 64);
            wait_rises(base + 1);
            if (i == 63) check("seq_63", 32'(rise_bus[21:16]), 32'd63);
            if (i == 64) check("seq_wrap", 32'(rise_bus[21:16]), 32'd0);
            if (i == 65) check("seq_after_last", 32'(rise_bus[21:16]), 32'd0);
        end
        wait_idle();

        // Last word carrying seq 5.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            base = n_rise;
            send(16'($urandom), 1'b0);
            wait_rises(base + 1);
        end
        base = n_rise;
        send(16'h1234, 1'b1);
        wait_rises(base + 1);
        check("last_word", 32'(rise_bus), 32'hC51234);
        base = n_rise;
        send(16'h7777, 1'b0);
        wait_rises(base + 1);
        check("seq_cleared", 32'(rise_bus[21:16]), 32'd0);
        wait_idle();

        // Reset while strobe is held high.
        host_auto = 1'b0;
        man_ack   = 1'b0;
        base = n_rise;
        send(16'h5A5A, 1'b0);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        wait_rises(base + 1);
        @(negedge clk);
        check("held_in_strobe", 32'(out_bus[23]), 32'd1);
        do_reset();
        host_auto = 1'b1;
        base = n_rise;
        repeat (40) @(negedge clk);
        check("no_strobe_after_rst", 32'(n_rise), 32'(base));
        check("idle_after_rst", 32'(busy), 32'd0);

        // Ack glitch coinciding with setup must be ignored.
        host_auto = 1'b0;
        man_ack   = 1'b0;
        base = n_rise;
        @(negedge clk);
        check("glitch_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h0F0F;
        in_last  = 1'b0;
        man_ack  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        model_q.push_back({1'b0, 16'h0F0F});
        @(negedge clk);
        in_valid = 1'b0;
        man_ack  = 1'b0;
        wait_rises(base + 1);
        check("glitch_latency", 32'(rise_cyc - acc_cyc), 32'(SETUP + 1));
        check("glitch_word", 32'(rise_bus), 32'h800F0F);
        repeat (5) @(negedge clk);
        check("glitch_strobe_held", 32'(out_bus[23]), 32'd1);
        host_auto = 1'b1;
        wait_idle();

        // Random traffic with a slow, jittery host.
        host_dly = 4;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
            send(16'($urandom), $urandom_range(0, 7) == 0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
